mem_fill_resp: RTL and testbench

Memory-side responder for the read-only cache line-fill protocol. It answers word requests (`i_mem_req`/`i_mem_addr`) from a cache miss engine with acknowledged data (`o_mem_ack`/`o_mem_data`) from an internal word-addressed memory. Wait states are programmable, and a sequential-burst fast path can be compiled in. The memory is preloaded through a separate load port by the boot loader or the bench.

---
 rtl/mem_fill_resp.sv | 189 ++++++++++++++++++
 tb/tb_mem_fill_resp.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_resp.sv
// -----------------------------------------------------------------------------
// mem_fill_resp
//
// Memory-side responder for a read-only cache line-fill protocol. A cache miss
// engine requests single 32-bit words (i_mem_req / i_mem_addr). The block
// answers from an internal word-addressed array with o_mem_ack / o_mem_data
// after a programmable number of wait states. The array is preloaded through
// a separate load port.
//
// Compile-time option:
//   MEM_FILL_RESP_BURST_EN - when defined, the remaining words of a cache line
//                            are acknowledged back-to-back (one per cycle) once
//                            the first word of the line has been acknowledged.
//
// Parameters:
//   MEM_ADDR_WIDTH - word-address width of the internal array (2^N words)
//   WAIT_STATES    - extra cycles before each non-burst acknowledge (0..15)
//   BLOCK_WIDTH    - log2 of words per cache line (burst wrap boundary)
//
// Ports:
//   i_ck        - clock, rising edge
//   i_rb        - asynchronous active-low reset
//   i_mem_req   - word request, held until acknowledged
//   i_mem_addr  - requested word address (upper bits alias)
//   o_mem_ack   - o_mem_data is valid for i_mem_addr this cycle
//   o_mem_data  - read data (registered array output)
//   i_ld_we     - load-port write strobe
//   i_ld_addr   - load-port word address
//   i_ld_data   - load-port write data
//   o_ack_cnt   - number of acknowledges since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module mem_fill_resp #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int WAIT_STATES    = 2,
    parameter int BLOCK_WIDTH    = 3
) (
    input  logic                      i_ck,
    input  logic                      i_rb,
    input  logic                      i_mem_req,
    input  logic [29:0]               i_mem_addr,
    output logic                      o_mem_ack,
    output logic [31:0]               o_mem_data,
    input  logic                      i_ld_we,
    input  logic [MEM_ADDR_WIDTH-1:0] i_ld_addr,
    input  logic [31:0]               i_ld_data,
    output logic [15:0]               o_ack_cnt
);

`ifdef MEM_FILL_RESP_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] mem [2**MEM_ADDR_WIDTH];
    logic [31:0] rd_data;
    logic [29:0] addr_rg;
    logic [3:0]  wcnt;

    logic        rd_en;
    logic [29:0] rd_addr;
    logic        burst_go;
    logic        line_last;
    logic [29:0] addr_inc;

    // Next word of the same line: only the in-line offset advances, so the
    // line base is never crossed.
    assign line_last = &addr_rg[BLOCK_WIDTH-1:0];
    assign addr_inc  = {addr_rg[29:BLOCK_WIDTH],
                        addr_rg[BLOCK_WIDTH-1:0] + BLOCK_WIDTH'(1)};

    assign o_mem_data = rd_data;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge i_ck or negedge i_rb) begin
        if (!i_rb) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (i_mem_req) begin
                    state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                // A withdrawn request abandons the read; it is not acked.
                if (!i_mem_req) begin
                    state_nxt = S_IDLE;
                end else if (wcnt == 4'd1) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                // Any mismatch returns to IDLE, which re-issues on the new
                // address in the following cycle.
                state_nxt = burst_go ? S_ACK : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / read-issue logic
    // ------------------------------------------------------------------
    always_comb begin
        o_mem_ack = 1'b0;
        burst_go  = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = i_mem_addr;
        unique case (state)
            S_IDLE: begin
                rd_en = i_mem_req;
            end
            S_ACK: begin
                // The pending data belongs to addr_rg; only ack it if the
                // requester is still asking for exactly that word.
                o_mem_ack = i_mem_req && (i_mem_addr == addr_rg);
                burst_go  = BURST_EN && o_mem_ack && !line_last;
                rd_en     = burst_go;
                rd_addr   = addr_inc;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_ck or negedge i_rb) begin
        if (!i_rb) begin
            rd_data   <= '0;
            addr_rg   <= '0;
            wcnt      <= '0;
            o_ack_cnt <= '0;
        end else begin
            if (rd_en) begin
                addr_rg <= rd_addr;
                rd_data <= mem[rd_addr[MEM_ADDR_WIDTH-1:0]];
            end

            if (state == S_IDLE && i_mem_req) begin
                wcnt <= 4'(WAIT_STATES);
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end

            if (o_mem_ack) begin
                o_ack_cnt <= o_ack_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array (load-port write side)
    // ------------------------------------------------------------------
    // NOTE: the array has no reset; its contents come from the load port, and
    // a reset term would prevent mapping onto a RAM macro. A read and a write
    // to the same word at the same edge return the old word.
    always_ff @(posedge i_ck) begin
        if (i_ld_we) begin
            mem[i_ld_addr] <= i_ld_data;
        end
    end

endmodule

// File: tb/tb_mem_fill_resp.sv
// -----------------------------------------------------------------------------
// tb_mem_fill_resp
//
// Self-checking bench for mem_fill_resp. Keeps a word-level model of the array
// contents and derives expected ack timing from the protocol latency rules.
// Honors MEM_FILL_RESP_BURST_EN for the line-fill timing expectations.
// -----------------------------------------------------------------------------
module tb_mem_fill_resp;

    localparam int WS = 2;
    localparam int AW = 10;
    localparam int BW = 3;

`ifdef MEM_FILL_RESP_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          i_ck       = 1'b0;
    logic          i_rb       = 1'b1;
    logic          i_mem_req  = 1'b0;
    logic [29:0]   i_mem_addr = '0;
    logic          o_mem_ack;
    logic [31:0]   o_mem_data;
    logic          i_ld_we    = 1'b0;
    logic [AW-1:0] i_ld_addr  = '0;
    logic [31:0]   i_ld_data  = '0;
    logic [15:0]   o_ack_cnt;

    mem_fill_resp #(
        .MEM_ADDR_WIDTH (AW),
        .WAIT_STATES    (WS),
        .BLOCK_WIDTH    (BW)
    ) dut (
        .i_ck       (i_ck),
        .i_rb       (i_rb),
        .i_mem_req  (i_mem_req),
        .i_mem_addr (i_mem_addr),
        .o_mem_ack  (o_mem_ack),
        .o_mem_data (o_mem_data),
        .i_ld_we    (i_ld_we),
        .i_ld_addr  (i_ld_addr),
        .i_ld_data  (i_ld_data),
        .o_ack_cnt  (o_ack_cnt)
    );

    always #5 i_ck = ~i_ck;

    int unsigned cyc = 0;
    always @(posedge i_ck) cyc <= cyc + 1;

    // Reference state: array contents and number of completed transactions.
    logic [31:0] model [1 << AW];
    int unsigned exp_cnt  = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge i_ck);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        i_ld_we   = 1'b1;
        i_ld_addr = a;
        i_ld_data = d;
        step();
        i_ld_we   = 1'b0;
        model[a]  = d;
    endtask

    // Wait (bounded) until ack is visible; lat is cycles since t0.
    task automatic wait_ack(output int unsigned lat, input int unsigned t0);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            #1;
            if (o_mem_ack === 1'b1) seen = 1'b1;
            else step();
        end
        lat = cyc - t0;
        check("ack_seen", 32'(seen), 32'd1);
    endtask

    // One isolated request followed by an idle gap that returns the DUT to IDLE.
    task automatic single_req(input string tag, input logic [29:0] a, input int gap);
        int unsigned t0;
        int unsigned lat;
        logic [31:0] want;
        want       = model[a[AW-1:0]];
        i_mem_req  = 1'b1;
        i_mem_addr = a;
        t0         = cyc;
        wait_ack(lat, t0);
        check({tag, "_lat"}, 32'(lat), 32'(1 + WS));
        check({tag, "_data"}, o_mem_data, want);
        step();
        exp_cnt++;
        i_mem_req = 1'b0;
        check({tag, "_cnt"}, 32'(o_ack_cnt), 32'(exp_cnt[15:0]));
        for (int g = 0; g < gap; g++) begin
            #1;
            check({tag, "_gap_noack"}, 32'(o_mem_ack), 32'd0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0;
        int unsigned lat;
        int unsigned last;
        logic [29:0] a30;
        logic [AW-1:0] addrs [$];

        // ---------------- reset ----------------
        #1 i_rb = 1'b0;
        repeat (3) @(posedge i_ck);
        #1;
        check("rst_ack", 32'(o_mem_ack), 32'd0);
        check("rst_data", o_mem_data, 32'd0);
        check("rst_cnt", 32'(o_ack_cnt), 32'd0);
        @(negedge i_ck);
        i_rb = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            #1;
            check("idle_noack", 32'(o_mem_ack), 32'd0);
            step();
        end
        check("idle_data", o_mem_data, 32'd0);
        check("idle_cnt", 32'(o_ack_cnt), 32'd0);

        // ---------------- single word, then aliased address ----------------
        load(10'h008, 32'hDEAD_BEEF);
        single_req("word008", 30'h008, 2);
        single_req("alias", 30'h3FFF_FC08, 2);

        // ---------------- line fill 0x40..0x47 ----------------
        for (int i = 0; i < 8; i++) load(AW'(10'h040 + i), 32'h1000 + 32'(i));
        i_mem_req  = 1'b1;
        i_mem_addr = 30'h040;
        t0         = cyc;
        last       = 0;
        for (int k = 0; k < 8; k++) begin
            wait_ack(lat, t0);
            check("fill_cyc", 32'(lat),
                  BURST ? 32'((1 + WS) + k) : 32'(k * (2 + WS) + 1 + WS));
            check("fill_data", o_mem_data, 32'h1000 + 32'(k));
            last = lat;
            step();
            exp_cnt++;
            i_mem_addr = i_mem_addr + 30'd1;
        end
        i_mem_req = 1'b0;
        check("fill_total", 32'(last + 1), BURST ? 32'd11 : 32'd32);
        check("fill_cnt", 32'(o_ack_cnt), 32'(exp_cnt[15:0]));
        step();
        step();

        // ---------------- request withdrawn during WAIT ----------------
        load(10'h010, 32'hA5A5_0010);
        load(10'h020, 32'h5A5A_0020);
        i_mem_req  = 1'b1;
        i_mem_addr = 30'h020;
        step();
        i_mem_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("abort_noack", 32'(o_mem_ack), 32'd0);
            step();
        end
        check("abort_cnt", 32'(o_ack_cnt), 32'(exp_cnt[15:0]));
        single_req("after_abort", 30'h010, 2);

        // ---------------- load-port writes to a word being read ----------------
        load(10'h030, 32'h1111_1111);
        i_mem_req  = 1'b1;
        i_mem_addr = 30'h030;
        i_ld_we    = 1'b1;
        i_ld_addr  = 10'h030;
        i_ld_data  = 32'h2222_2222;
        t0         = cyc;
        step();
        i_ld_data = 32'h3333_3333;
        step();
        i_ld_we = 1'b0;
        model[10'h030] = 32'h3333_3333;
        wait_ack(lat, t0);
        check("rdw_lat", 32'(lat), 32'(1 + WS));
        check("rdw_data", o_mem_data, 32'h1111_1111);
        step();
        exp_cnt++;
        i_mem_req = 1'b0;
        step();
        step();
        single_req("rdw_new", 30'h030, 2);

        // ---------------- reset while in ACK ----------------
        i_mem_req  = 1'b1;
        i_mem_addr = 30'h008;
        t0         = cyc;
        wait_ack(lat, t0);
        check("pre_rst_lat", 32'(lat), 32'(1 + WS));
        i_rb = 1'b0;
        #1;
        check("rst_ack_drop", 32'(o_mem_ack), 32'd0);
        check("rst_ack_data", o_mem_data, 32'd0);
        check("rst_ack_cnt", 32'(o_ack_cnt), 32'd0);
        exp_cnt = 0;
        @(negedge i_ck);
        i_rb = 1'b1;
        t0   = cyc;
        wait_ack(lat, t0);
        check("post_rst_lat", 32'(lat), 32'(1 + WS));
        check("post_rst_data", o_mem_data, 32'hDEAD_BEEF);
        step();
        exp_cnt++;
        i_mem_req = 1'b0;
        check("post_rst_cnt", 32'(o_ack_cnt), 32'(exp_cnt[15:0]));
        step();
        step();

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 16; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(256, 1023));
            load(a, $urandom());
            addrs.push_back(a);
        end
        for (int i = 0; i < 20; i++) begin
            int idx;
            idx = int'($urandom_range(0, 15));
            a30 = 30'($urandom());
            a30[AW-1:0] = addrs[idx];
            single_req("rand", a30, int'($urandom_range(2, 4)));
        end

        check("final_cnt", 32'(o_ack_cnt), 32'(exp_cnt[15:0]));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
